// File: rtl/uart_pkg.sv
// Shared UART 16750 definitions: IIR interrupt identification codes and
// character-length helper used by the interrupt-source logic.
package uart_pkg;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_MSR  = 4'b0000;

  // start + data(5..8) + parity + stop(1..2); result 7..12
  function automatic logic [3:0] char_bits(input logic [3:0] lcr);
    logic [3:0] bits;
    bits = 4'd1 + (4'd5 + {2'b00, lcr[1:0]}) + {3'b000, lcr[3]} + (4'd1 + {3'b000, lcr[2]});
    return bits;
  endfunction

endpackage

// File: rtl/uart_char_timeout.sv
// Character-timeout counter: counts 16x baud ticks while RX data sits
// unread and flags CTI once four character times have elapsed.
module uart_char_timeout
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUDCE,
  input  logic [3:0] LCR,
  input  logic       FIFO_EN,
  input  logic       RF_EMPTY,
  input  logic       RF_PUSH,
  input  logic       RF_POP,
  output logic       CTI
);

  logic [9:0] count;
  logic [9:0] count_next;
  logic [9:0] threshold;
  logic       clear;

  // 4 characters x 16 ticks per bit = 64 ticks per character bit
  assign threshold = {char_bits(LCR), 6'b000000};
  assign clear     = RF_PUSH | RF_POP | RF_EMPTY | ~FIFO_EN;

  // Clamping at threshold also pulls an over-range count down after an
  // LCR change shortens the character, so CTI asserts immediately.
  always_comb begin
    count_next = count;
    if (clear)
      count_next = '0;
    else if (count >= threshold)
      count_next = threshold;
    else if (BAUDCE)
      count_next = count + 10'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
      CTI   <= 1'b0;
    end else begin
      count <= count_next;
      CTI   <= (count_next == threshold);
    end
  end

endmodule

// File: rtl/uart_int_source.sv
// UART 16750 interrupt-source conditioning: produces the THI and CTI level
// inputs for the IIR/INT priority encoder.
module uart_int_source
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUDCE,
  input  logic [3:0] LCR,
  input  logic       FIFO_EN,
  input  logic       RF_EMPTY,
  input  logic       RF_PUSH,
  input  logic       RF_POP,
  input  logic       THR_EMPTY,
  input  logic       THR_WRITE,
  input  logic       IER_THRI_SET,
  input  logic       IIR_READ,
  input  logic [3:0] IIR_CUR,
  output logic       THI,
  output logic       CTI
);

  logic thr_empty_q;
  logic thr_empty_prev;
  logic thr_empty_rise;
  logic thi_next;

  // Both samples reset to 1 so an already-empty THR after reset is not an edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      thr_empty_q    <= 1'b1;
      thr_empty_prev <= 1'b1;
    end else begin
      thr_empty_q    <= THR_EMPTY;
      thr_empty_prev <= thr_empty_q;
    end
  end

  assign thr_empty_rise = thr_empty_q & ~thr_empty_prev;

  always_comb begin
    thi_next = THI;
    if (THR_WRITE)
      thi_next = 1'b0;
    else if (thr_empty_rise || (IER_THRI_SET && thr_empty_q))
      thi_next = 1'b1;
    else if (IIR_READ && (IIR_CUR == IIR_THRE))
      thi_next = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      THI <= 1'b0;
    else
      THI <= thi_next;
  end

  uart_char_timeout u_char_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .BAUDCE   (BAUDCE),
    .LCR      (LCR),
    .FIFO_EN  (FIFO_EN),
    .RF_EMPTY (RF_EMPTY),
    .RF_PUSH  (RF_PUSH),
    .RF_POP   (RF_POP),
    .CTI      (CTI)
  );

endmodule

// File: tb/tb_uart_int_source.sv
// Scoreboard bench for uart_int_source: a cycle model predicts THI/CTI for
// each driven cycle and a monitor compares after every clock edge.
module tb_uart_int_source;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BAUDCE = 1'b0;
  logic [3:0] LCR = 4'b0011;
  logic       FIFO_EN = 1'b1;
  logic       RF_EMPTY = 1'b0;
  logic       RF_PUSH = 1'b0;
  logic       RF_POP = 1'b0;
  logic       THR_EMPTY = 1'b1;
  logic       THR_WRITE = 1'b0;
  logic       IER_THRI_SET = 1'b0;
  logic       IIR_READ = 1'b0;
  logic [3:0] IIR_CUR = 4'b0001;
  logic       THI;
  logic       CTI;

  uart_int_source dut (
    .CLK          (CLK),
    .RST          (RST),
    .BAUDCE       (BAUDCE),
    .LCR          (LCR),
    .FIFO_EN      (FIFO_EN),
    .RF_EMPTY     (RF_EMPTY),
    .RF_PUSH      (RF_PUSH),
    .RF_POP       (RF_POP),
    .THR_EMPTY    (THR_EMPTY),
    .THR_WRITE    (THR_WRITE),
    .IER_THRI_SET (IER_THRI_SET),
    .IIR_READ     (IIR_READ),
    .IIR_CUR      (IIR_CUR),
    .THI          (THI),
    .CTI          (CTI)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic thi; logic cti; } exp_t;
  exp_t sb[$];

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model state: raw THR_EMPTY history, THI, timeout tick count
  bit m_last1 = 1'b1;
  bit m_last2 = 1'b1;
  bit m_thi   = 1'b0;
  int m_ticks = 0;

  function automatic int timeout_ticks(input logic [3:0] l);
    int data_bits;
    int stop_bits;
    int parity_bits;
    data_bits   = 5 + int'(l[1:0]);
    parity_bits = l[3] ? 1 : 0;
    stop_bits   = l[2] ? 2 : 1;
    return 4 * 16 * (1 + data_bits + parity_bits + stop_bits);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("thi", THI, e.thi);
      check("cti", CTI, e.cti);
    end
  end

  // Called at a falling edge with inputs already set: predict the state
  // after the next rising edge, then advance one clock.
  task automatic cycle();
    bit edge_seen;
    int lim;
    edge_seen = m_last1 && !m_last2;
    if (THR_WRITE)                                   m_thi = 1'b0;
    else if (edge_seen || (IER_THRI_SET && m_last1)) m_thi = 1'b1;
    else if (IIR_READ && IIR_CUR == 4'b0010)         m_thi = 1'b0;
    m_last2 = m_last1;
    m_last1 = THR_EMPTY;
    lim = timeout_ticks(LCR);
    if (RF_PUSH || RF_POP || RF_EMPTY || !FIFO_EN) m_ticks = 0;
    else begin
      m_ticks = m_ticks + (BAUDCE ? 1 : 0);
      if (m_ticks > lim) m_ticks = lim;
    end
    sb.push_back('{thi: m_thi, cti: (m_ticks == lim)});
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      BAUDCE = 1'b1; cycle();
      BAUDCE = 1'b0; cycle();
    end
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    run(5);
    check("thi_after_reset_thr_empty_high", THI, 1'b0);

    // THR empty edge sets THI two cycles after the raw edge
    THR_EMPTY = 1'b0; run(3);
    THR_EMPTY = 1'b1; cycle();
    check("thi_one_cycle_after_edge", THI, 1'b0);
    cycle();
    check("thi_two_cycles_after_edge", THI, 1'b1);
    IIR_READ = 1'b1; IIR_CUR = 4'b0100; cycle();
    IIR_READ = 1'b0; run(2);
    check("thi_held_on_rda_read", THI, 1'b1);
    IIR_READ = 1'b1; IIR_CUR = 4'b0010; cycle();
    IIR_READ = 1'b0;
    check("thi_cleared_on_thre_read", THI, 1'b0);

    // Edge detected in the same cycle as a THR write
    THR_EMPTY = 1'b0; run(3);
    THR_EMPTY = 1'b1; cycle();
    THR_WRITE = 1'b1; cycle();
    THR_WRITE = 1'b0; run(2);
    check("thi_write_beats_edge", THI, 1'b0);
    IER_THRI_SET = 1'b1; cycle();
    IER_THRI_SET = 1'b0;
    check("thi_set_by_ier", THI, 1'b1);
    IIR_READ = 1'b1; IIR_CUR = 4'b0010; IER_THRI_SET = 1'b1; cycle();
    IIR_READ = 1'b0; IER_THRI_SET = 1'b0;
    check("thi_set_beats_thre_read", THI, 1'b1);

    // 8N1 timeout: 640 ticks
    LCR = 4'b0011; RF_POP = 1'b1; cycle(); RF_POP = 1'b0;
    ticks(639);
    check("cti_8n1_before_640", CTI, 1'b0);
    ticks(1);
    check("cti_8n1_at_640", CTI, 1'b1);
    RF_POP = 1'b1; cycle(); RF_POP = 1'b0;
    check("cti_cleared_by_pop", CTI, 1'b0);

    // Push at tick 639 restarts the count
    ticks(638);
    BAUDCE = 1'b1; RF_PUSH = 1'b1; cycle();
    BAUDCE = 1'b0; RF_PUSH = 1'b0; cycle();
    ticks(639);
    check("cti_restart_before_640", CTI, 1'b0);
    ticks(1);
    check("cti_restart_at_640", CTI, 1'b1);

    // 5E2 timeout with clear conditions held
    LCR = 4'b1100; RF_EMPTY = 1'b1;
    ticks(700);
    check("cti_suppressed_rf_empty", CTI, 1'b0);
    RF_EMPTY = 1'b0; cycle();
    ticks(575);
    check("cti_5e2_before_576", CTI, 1'b0);
    ticks(1);
    check("cti_5e2_at_576", CTI, 1'b1);
    FIFO_EN = 1'b0;
    ticks(700);
    check("cti_suppressed_fifo_off", CTI, 1'b0);
    FIFO_EN = 1'b1; cycle();
    ticks(576);
    check("cti_5e2_after_fifo_on", CTI, 1'b1);

    // Shortening the character past the current count asserts CTI at once
    LCR = 4'b0011; RF_POP = 1'b1; cycle(); RF_POP = 1'b0;
    ticks(600);
    check("cti_before_lcr_change", CTI, 1'b0);
    LCR = 4'b0000; cycle();
    check("cti_after_lcr_change", CTI, 1'b1);

    // Asynchronous reset mid-activity
    ticks(3);
    RST = 1'b1;
    #1;
    check("thi_async_reset", THI, 1'b0);
    check("cti_async_reset", CTI, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    m_last1 = 1'b1; m_last2 = 1'b1; m_thi = 1'b0; m_ticks = 0;
    THR_EMPTY = 1'b1;
    run(5);
    check("thi_after_mid_reset", THI, 1'b0);

    // Randomized phase
    for (int i = 0; i < 20000; i++) begin
      BAUDCE       = ($urandom_range(0, 3) != 0);
      RF_PUSH      = ($urandom_range(0, 999) == 0);
      RF_POP       = ($urandom_range(0, 999) == 0);
      RF_EMPTY     = ($urandom_range(0, 1999) == 0);
      FIFO_EN      = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 1499) == 0) LCR = 4'($urandom);
      if ($urandom_range(0, 7) == 0) THR_EMPTY = ~THR_EMPTY;
      THR_WRITE    = ($urandom_range(0, 15) == 0);
      IER_THRI_SET = ($urandom_range(0, 15) == 0);
      IIR_READ     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       IIR_CUR = 4'b0010;
        1:       IIR_CUR = 4'b0100;
        2:       IIR_CUR = 4'b1100;
        default: IIR_CUR = 4'b0001;
      endcase
      cycle();
    end

    @(negedge CLK);
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
